imem_dmem_arbiter: RTL

//  Shares one stall-capable memory port between instruction fetch (read-only)
//  and the memory stage (read/write) for the pipelined CPU. Sequences each

---
 rtl/imem_dmem_arbiter_if.sv | 42 ++++
 rtl/imem_dmem_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter_if.sv
// Bundle between the arbiter, the two requesters and the shared memory port.
// master: arbiter side; slave: requesters plus memory side.
interface imem_dmem_arbiter_if;
   logic        if_req;
   logic [15:0] if_addr;
   logic        if_done;
   logic [15:0] if_data;
   logic        if_err;
   logic        if_stall;
   logic        d_rd;
   logic        d_wr;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_done;
   logic [15:0] d_rdata;
   logic        d_err;
   logic        d_stall;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic        mem_stall;
   logic        mem_done;
   logic [15:0] mem_rdata;
   logic        mem_err;

   modport master (
      input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata,
      input  mem_stall, mem_done, mem_rdata, mem_err,
      output if_done, if_data, if_err, if_stall,
      output d_done, d_rdata, d_err, d_stall,
      output mem_addr, mem_wdata, mem_rd, mem_wr
   );

   modport slave (
      output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata,
      output mem_stall, mem_done, mem_rdata, mem_err,
      input  if_done, if_data, if_err, if_stall,
      input  d_done, d_rdata, d_err, d_stall,
      input  mem_addr, mem_wdata, mem_rd, mem_wr
   );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one stall-capable memory port between fetch and the memory stage.
// Ports: clk, rst (sync, active-high), bus (master side of the bundle).
module imem_dmem_arbiter #(
   parameter int STARVE_MAX = 3,
   parameter int TIMEOUT    = 64
) (
   input  logic                clk,
   input  logic                rst,
   imem_dmem_arbiter_if.master bus
);
   localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t        state;
   state_t        state_nx;
   logic [SW-1:0] starve;
   logic [TW-1:0] tcnt;
   logic          own_d;
   logic          wr_q;
   logic          err_q;
   logic [15:0]   addr_q;
   logic [15:0]   wdata_q;
   logic [15:0]   if_data_q;
   logic [15:0]   d_rdata_q;
   logic          d_any;
   logic          grant_d;
   logic          tmo;
   logic          rd_s;
   logic          wr_s;
   logic          if_done_s;
   logic          d_done_s;

   assign d_any = bus.d_rd | bus.d_wr;
   // fetch takes the port only when data is idle or fetch has lost too often
   assign grant_d = d_any & ~(bus.if_req & (starve == SW'(STARVE_MAX)));
   assign tmo = (state == WAIT) & (tcnt == TW'(TIMEOUT - 1));

   always_comb begin
      state_nx  = state;
      rd_s      = 1'b0;
      wr_s      = 1'b0;
      if_done_s = 1'b0;
      d_done_s  = 1'b0;
      unique case (state)
         IDLE: if (bus.if_req || d_any) state_nx = REQ;
         REQ: begin
            rd_s = ~wr_q;
            wr_s = wr_q;
            if (!bus.mem_stall) state_nx = WAIT;
         end
         WAIT: if (bus.mem_done || tmo) state_nx = RESP;
         RESP: begin
            if_done_s = ~own_d;
            d_done_s  = own_d;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         starve    <= '0;
         tcnt      <= '0;
         own_d     <= 1'b0;
         wr_q      <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         if_data_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state <= state_nx;
         unique case (state)
            IDLE: begin
               if (bus.if_req || d_any) begin
                  own_d   <= grant_d;
                  wr_q    <= grant_d & bus.d_wr;
                  addr_q  <= grant_d ? bus.d_addr : bus.if_addr;
                  wdata_q <= grant_d ? bus.d_wdata : 16'h0000;
                  tcnt    <= '0;
                  if (!grant_d)
                     starve <= '0;
                  else if (bus.if_req && starve != SW'(STARVE_MAX))
                     starve <= starve + SW'(1);
               end
            end
            WAIT: begin
               if (bus.mem_done || tmo) begin
                  // a timeout reports an error with zero data
                  err_q <= bus.mem_done ? bus.mem_err : 1'b1;
                  if (own_d)
                     d_rdata_q <= (bus.mem_done && !wr_q) ?
                                  bus.mem_rdata : 16'h0000;
                  else
                     if_data_q <= bus.mem_done ? bus.mem_rdata : 16'h0000;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            RESP: tcnt <= '0;
            default: ;
         endcase
      end
   end

   assign bus.mem_rd    = rd_s;
   assign bus.mem_wr    = wr_s;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.if_done   = if_done_s;
   assign bus.if_data   = if_data_q;
   assign bus.if_err    = if_done_s & err_q;
   assign bus.if_stall  = bus.if_req & ~if_done_s;
   assign bus.d_done    = d_done_s;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.d_err     = d_done_s & err_q;
   assign bus.d_stall   = d_any & ~d_done_s;
endmodule
